// File: rtl/rom_cache_segment.sv
// Per-ROM front end: direct-mapped cache of 32-bit SDRAM words in front of rom_controller.
// Hits answer combinationally; each miss issues one req/ack/valid read to fill its line.
module rom_cache_segment #(
  parameter int          ROM_ADDR_WIDTH   = 18,
  parameter int          ROM_DATA_WIDTH   = 16,
  parameter logic [23:0] ROM_OFFSET       = 24'h000000,
  parameter int          CACHE_LINES_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      cs,
  input  logic                      oe,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [ROM_DATA_WIDTH-1:0] rom_data,
  output logic [22:0]               ctrl_addr,
  output logic                      ctrl_req,
  input  logic                      ctrl_ack,
  input  logic                      ctrl_valid,
  input  logic [31:0]               ctrl_data,
  output logic                      ctrl_hit
);

  localparam int LANES     = 32 / ROM_DATA_WIDTH;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int LB        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int WORD_W    = ROM_ADDR_WIDTH - LANE_BITS;
  localparam int TAG_W     = WORD_W - CACHE_LINES_LOG2;
  localparam int LINES     = 1 << CACHE_LINES_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [WORD_W-1:0]           w_word;
  logic [LB-1:0]               w_lane;
  logic [CACHE_LINES_LOG2-1:0] w_index;
  logic [TAG_W-1:0]            w_tag;
  logic [CACHE_LINES_LOG2-1:0] w_fill_index;
  logic [TAG_W-1:0]            w_fill_tag;
  logic                        w_fill;

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_discard;
  logic [WORD_W-1:0] r_word;
  logic [LB-1:0]     r_lane;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES];

  // Full 32-bit client width has a single lane, so there are no lane bits to slice.
  generate
    if (LANE_BITS > 0) begin : g_lanes
      assign w_lane = rom_addr[LANE_BITS-1:0];
    end else begin : g_single_lane
      assign w_lane = '0;
    end
  endgenerate

  assign w_word       = rom_addr[ROM_ADDR_WIDTH-1:LANE_BITS];
  assign w_index      = w_word[CACHE_LINES_LOG2-1:0];
  assign w_tag        = w_word[WORD_W-1:CACHE_LINES_LOG2];
  assign w_fill_index = r_word[CACHE_LINES_LOG2-1:0];
  assign w_fill_tag   = r_word[WORD_W-1:CACHE_LINES_LOG2];

  function automatic logic [ROM_DATA_WIDTH-1:0] f_lane(input logic [31:0] w, input logic [LB-1:0] l);
    logic [31:0] s;
    s = w >> (ROM_DATA_WIDTH * int'(l));
    return s[ROM_DATA_WIDTH-1:0];
  endfunction

  // A fill landing together with flush, or after a flush during the miss, is dropped.
  assign w_fill    = (r_state == S_WAIT) & ctrl_valid & ~r_discard & ~flush;
  assign ctrl_hit  = cs & oe & r_valid[w_index] & (r_tag[w_index] == w_tag) & ~flush;
  assign ctrl_req  = r_req;
  assign ctrl_addr = {1'b0, ROM_OFFSET[23:2]} + 23'(r_word);
  assign rom_data  = ((r_state == S_WAIT) && ctrl_valid) ? f_lane(ctrl_data, r_lane)
                                                         : f_lane(r_data[w_index], w_lane);

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= ctrl_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_discard <= 1'b0;
      r_word    <= '0;
      r_lane    <= '0;
      r_valid   <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_discard <= 1'b0;
          if (cs && oe && !ctrl_hit && !flush) begin
            r_word  <= w_word;
            r_lane  <= w_lane;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        // The request is never withdrawn once raised; the controller must see it through.
        S_REQ: begin
          if (flush) r_discard <= 1'b1;
          if (ctrl_ack) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) r_discard <= 1'b1;
          if (ctrl_valid) begin
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
